sub_serial: RTL
===============

Name: sub_serial

Overview:
Multi-cycle N-bit subtractor computing D = A − B − borrow_in, W bits per clock, LSB chunk first. It is the inverse-direction companion of the combinational N-bit adder. Each chunk is formed by the existing adder slice using inverted B and carry. Valid/ready handshake on both sides lets it sit between pipelined datapath stages.

Parameters:
N, 64, operand/result width in bits; N % W == 0 required (elaboration error otherwise)
W, 8, bits processed per cycle; latency = N/W cycles

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_reset  input  1  synchronous reset, active-high
i_valid  input  1  operand request valid
o_ready  output  1  block can accept operands
i_a  input  N  minuend
i_b  input  N  subtrahend
i_borrow_in  input  1  incoming borrow
o_valid  output  1  result valid
i_ready  input  1  consumer accepts result
o_d  output  N  difference, modulo 2^N
o_borrow_out  output  1  final borrow (1 iff A < B + borrow_in, unsigned)

Behaviour:
- Reset is synchronous and active-high. Reset values: o_ready=1, o_valid=0, o_d=0, o_borrow_out=0, state=IDLE, chunk counter=0.
- States: IDLE, BUSY, DONE.
- IDLE: o_ready=1. On i_valid && o_ready:
  - latch i_a, i_b and i_borrow_in into internal registers;
  - clear the counter;
  - go to BUSY.
- BUSY: o_ready=0, o_valid=0. Each cycle processes chunk k (bits k*W+W-1 : k*W):
  - {borrow', d_k} = a_k − b_k − borrow, computed as a_k + ~b_k + ~borrow, with borrow' = ~carry_out;
  - d_k is written into o_d's chunk k; borrow is registered for the next chunk;
  - counter increments; after chunk N/W−1 go to DONE.
- DONE: o_valid=1, and o_d / o_borrow_out are held stable. On i_ready go to IDLE; o_ready=1 from the next cycle.
- Latency: handshake accepted at edge t; o_valid first high in the cycle after edge t+N/W.
- Throughput: one operation per N/W+2 cycles. There is no overlap and no accept in the DONE cycle.
- i_a, i_b and i_borrow_in are don't-care outside the accept cycle; later changes never affect the result.
- i_valid while not ready is ignored (not queued). i_ready while o_valid=0 is ignored.
- Back-pressure: DONE may last indefinitely; all outputs stay constant.
- Reset mid-operation: any state returns to IDLE on the next edge. The partial result is discarded and o_valid never pulses.
- Wrap-around: the result is always mod 2^N (0 − 1 = 2^N−1, borrow_out=1).
- Simultaneous i_reset and i_valid: reset wins, and the request is not accepted.

Optional Feature:
SUB_SERIAL_OVERFLOW_EN
- Defined: adds output port o_overflow (1 bit), with reset value 0. It is valid with o_valid and set iff the signed two's-complement result overflowed (sign(A)≠sign(B) and sign(D)≠sign(A)). It is computed from the registered MSBs at the last chunk.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package sub_serial_pkg:
  - typedef enum of the state (IDLE, BUSY, DONE);
  - localparam helper for the counter width, $clog2(N/W) (minimum 1).
- Sub-module: reuse the existing adder with N=W as the per-chunk slice, driven with ~b_k and carry_in = ~borrow. There is no new combinational module.

Test Plan:
All cases use N=64, W=8.
1. a=5, b=3, borrow_in=0, i_ready=1 → o_d=2, o_borrow_out=0; o_valid asserted exactly 8 cycles after accept and held 1 cycle.
2. a=0, b=1, borrow_in=0 → o_d=2^64−1, o_borrow_out=1; same check with a=0, b=0, borrow_in=1 gives the same result.
3. a=b=2^64−1, borrow_in=1 → o_d=2^64−1, o_borrow_out=1. Then a=0x100, b=0x1 → o_d=0xFF, borrow_out=0 (tests borrow across the chunk boundary).
4. Back-pressure: i_ready=0 for 5 cycles after o_valid → o_d and o_valid stable, o_ready=0. A second i_valid pulse during this time is not accepted; after i_ready=1, o_ready returns the next cycle.
5. i_reset=1 during the 3rd BUSY cycle → next cycle o_ready=1, o_valid=0, o_d=0. A subsequent a=10, b=4 gives o_d=6.
6. With SUB_SERIAL_OVERFLOW_EN: a=0x8000_0000_0000_0000, b=1 → o_d=0x7FFF_FFFF_FFFF_FFFF, o_overflow=1. Then a=5, b=3 → o_overflow=0.

Source files
------------

// File: rtl/sub_serial_pkg.sv
// Shared types and sizing helpers for the serial subtractor (sub_serial).
package sub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk counter width; never narrower than one bit so a single-chunk build still has a counter.
  function automatic int cnt_width(input int chunks);
    return (chunks <= 1) ? 1 : $clog2(chunks);
  endfunction

endpackage

// File: rtl/sub_serial_adder.sv
// Plain W-bit ripple adder slice; the serial subtractor feeds it ~b and an inverted borrow.
module sub_serial_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, carry_in};

endmodule

// File: rtl/sub_serial.sv
// Multi-cycle N-bit subtractor D = A - B - borrow_in, W bits per clock, LSB chunk first.
// Optional signed-overflow output is enabled with `define SUB_SERIAL_OVERFLOW_EN.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_borrow_in,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_d,
  output logic         o_borrow_out,
`ifdef SUB_SERIAL_OVERFLOW_EN
  output logic         o_overflow,
`endif
  output state_t       o_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Upstream: o_ready is high only in IDLE. Downstream: o_valid is high only in DONE,
  // and o_d / o_borrow_out are stable for as long as o_valid stays high.

  localparam int CHUNKS = N / W;
  localparam int CNT_W  = cnt_width(CHUNKS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHUNKS - 1);

  if ((W < 1) || (N % W != 0)) begin : g_bad_params
    $error("sub_serial: N must be a positive multiple of W");
  end

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     a_reg;
  logic [N-1:0]     b_reg;
  logic             borrow;
  logic [W-1:0]     a_k;
  logic [W-1:0]     b_k;
  logic [W-1:0]     sum_k;
  logic             carry_k;
  logic             last;

  assign a_k  = a_reg[int'(cnt)*W +: W];
  assign b_k  = b_reg[int'(cnt)*W +: W];
  assign last = (cnt == LAST);

  // a - b - borrow == a + ~b + ~borrow; the slice's carry out is the inverted borrow.
  sub_serial_adder #(.N(W)) u_slice (
    .a         (a_k),
    .b         (~b_k),
    .carry_in  (~borrow),
    .sum       (sum_k),
    .carry_out (carry_k)
  );

  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      borrow       <= 1'b0;
      o_d          <= '0;
      o_borrow_out <= 1'b0;
`ifdef SUB_SERIAL_OVERFLOW_EN
      o_overflow   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_reg  <= i_a;
            b_reg  <= i_b;
            borrow <= i_borrow_in;
            cnt    <= '0;
          end
        end
        BUSY: begin
          o_d[int'(cnt)*W +: W] <= sum_k;
          borrow                <= ~carry_k;
          cnt                   <= last ? '0 : cnt + 1'b1;
          if (last) begin
            o_borrow_out <= ~carry_k;
`ifdef SUB_SERIAL_OVERFLOW_EN
            o_overflow   <= (a_reg[N-1] != b_reg[N-1]) && (sum_k[W-1] != a_reg[N-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign o_state = state;

endmodule
